// File: rtl/game_frame_renderer.sv
// game_frame_renderer: latches the game state on `go`, sweeps the 160x120
// raster once emitting one plot per pixel, and reports player/wall overlap.
module game_frame_renderer #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int DUDE_SIZE = 4,
  parameter int WALL_W    = 4,
  parameter int GAP_H     = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       startgame,
  input  logic [7:0] dude_x,
  input  logic [6:0] dude_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       hit
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_t;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [8:0] DUDE9  = 9'(DUDE_SIZE);
  localparam logic [8:0] WALL9  = 9'(WALL_W);
  localparam logic [8:0] GAP9   = 9'(GAP_H);

  state_t     state, state_nxt;
  logic [7:0] x_cnt;
  logic [6:0] y_cnt;
  logic       sg_q;
  logic [7:0] dx_q, wx_q;
  logic [6:0] dy_q, gy_q;
  logic       acc;
  logic       hit_q;

  logic       last_px;
  logic [8:0] px9, py9;
  logic       dude_px, wall_px, overlap;

  // Extents are compared in 9 bits so that edge-of-screen sums never wrap;
  // anything past the edge is simply never reached by the counters.
  assign px9     = {1'b0, x_cnt};
  assign py9     = {2'b00, y_cnt};
  assign last_px = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  assign dude_px = (px9 >= {1'b0, dx_q}) && (px9 < ({1'b0, dx_q} + DUDE9)) &&
                   (py9 >= {2'b00, dy_q}) && (py9 < ({2'b00, dy_q} + DUDE9));

  // A gap reaching past the bottom leaves only the upper wall segment, since
  // y never gets to gap_y+GAP_H.
  assign wall_px = (px9 >= {1'b0, wx_q}) && (px9 < ({1'b0, wx_q} + WALL9)) &&
                   ((py9 < {2'b00, gy_q}) || (py9 >= ({2'b00, gy_q} + GAP9)));

  assign overlap = (state == S_DRAW) && sg_q && dude_px && wall_px;

  assign plot  = (state == S_DRAW);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign hit   = hit_q;
  assign vga_x = x_cnt;
  assign vga_y = y_cnt;

  // Pixel colour from latched state and counters; player wins over wall.
  always_comb begin
    vga_colour = 3'b000;
    if (state == S_DRAW) begin
      if (!sg_q)        vga_colour = 3'b001;
      else if (dude_px) vga_colour = 3'b110;
      else if (wall_px) vga_colour = 3'b010;
      else              vga_colour = 3'b000;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_DRAW;
      S_DRAW:  if (last_px) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Shadow registers, raster counters and overlap tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_cnt <= '0;
      y_cnt <= '0;
      sg_q  <= 1'b0;
      dx_q  <= '0;
      dy_q  <= '0;
      wx_q  <= '0;
      gy_q  <= '0;
      acc   <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      case (state)
        S_LATCH: begin
          sg_q  <= startgame;
          dx_q  <= dude_x;
          dy_q  <= dude_y;
          wx_q  <= wall_x;
          gy_q  <= gap_y;
          x_cnt <= '0;
          y_cnt <= '0;
          acc   <= 1'b0;
        end
        S_DRAW: begin
          acc <= acc | overlap;
          if (last_px) begin
            // Counters park on the last pixel; the last pixel's overlap is
            // folded in directly so `hit` is valid alongside `done`.
            hit_q <= acc | overlap;
          end else if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 7'd1;
          end else begin
            x_cnt <= x_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/game_frame_renderer.md
# game_frame_renderer

Reads the game state that the game datapath writes (player square position, wall column position and gap) and turns it into a raster of pixel writes for the VGA adapter. On each `go` request it latches the state, sweeps every pixel of the 160x120 screen once, and emits one `plot` per pixel with that pixel's colour. While sweeping it detects any player/wall pixel overlap and reports it as `hit` with the frame-complete pulse, so the game controller can raise `endgame`.

## Interface
- `SCREEN_W`, 160, horizontal pixel count
- `SCREEN_H`, 120, vertical pixel count
- `DUDE_SIZE`, 4, player square edge in pixels
- `WALL_W`, 4, wall column width in pixels
- `GAP_H`, 32, vertical gap height in the wall

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain)
- `resetn`  in  1  synchronous, active-low reset
- `go`  in  1  frame render request; level sampled in IDLE
- `startgame`  in  1  0 = menu screen, 1 = game screen
- `dude_x`  in  8  player left column
- `dude_y`  in  7  player top row
- `wall_x`  in  8  wall left column
- `gap_y`  in  7  top row of the wall gap
- `vga_x`  out  8  pixel column
- `vga_y`  out  7  pixel row
- `vga_colour`  out  3  pixel colour, RGB
- `plot`  out  1  pixel write strobe; `vga_x`/`vga_y`/`vga_colour` are valid while it is high
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse at frame completion
- `hit`  out  1  overlap result of the last completed frame

## Operation
- FSM states: IDLE, LATCH, DRAW, DONE.
  - IDLE -> LATCH when `go`=1.
  - LATCH -> DRAW unconditionally.
  - DRAW -> DONE after pixel (SCREEN_W-1, SCREEN_H-1).
  - DONE -> IDLE unconditionally.
- LATCH:
  - Captures `startgame`, `dude_x`, `dude_y`, `wall_x` and `gap_y` into shadow registers.
  - Clears the column and row counters to 0.
  - Clears the internal overlap accumulator.
- Input changes after LATCH do not affect the frame in progress.
- DRAW:
  - `plot`=1 on every cycle.
  - `vga_x`/`vga_y` are the counters; x increments fastest.
  - At x=SCREEN_W-1, x returns to 0 and y increments.
- Colour, decided from the latched values:
  - Menu (`startgame`=0): every pixel is 3'b001.
  - Game, player pixel: `dude_x` <= x < `dude_x`+DUDE_SIZE and `dude_y` <= y < `dude_y`+DUDE_SIZE. Colour 3'b110.
  - Game, wall pixel: `wall_x` <= x < `wall_x`+WALL_W and (y < `gap_y` or y >= `gap_y`+GAP_H). Colour 3'b010.
  - Otherwise 3'b000.
  - The player has priority over the wall.
- Width rules:
  - All range sums use 9-bit arithmetic, so there is no wrap-around.
  - Extents past the screen edge are simply never reached by the counters (clipped).
  - If `gap_y`+GAP_H >= SCREEN_H, the wall is solid above `gap_y` only.
- Overlap:
  - The accumulator sets on any DRAW pixel that is both a player pixel and a wall pixel, in game mode only.
  - On entry to DONE the accumulator is copied to `hit`.
  - `hit` holds until the next DONE or reset.
  - In menu mode `hit` becomes 0.
- `go` while busy is ignored. It is not queued.
- `go` held high continuously re-renders back-to-back, with one IDLE cycle between frames.

## Timing
- Reset (`resetn`=0 at a clock edge), including mid-frame:
  - Next state is IDLE.
  - `plot`=0, `busy`=0, `done`=0, `hit`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
  - A partial frame is abandoned with no `done`.
- With `go` sampled at edge k:
  - LATCH after edge k.
  - First `plot` (pixel 0,0) in the cycle after edge k+1.
- `plot` is high for exactly SCREEN_W*SCREEN_H = 19200 consecutive cycles.
- `done` is high for 1 cycle, immediately after the last plot cycle. `hit` is valid in the same cycle.
- Frame latency from `go` to `done` is 19202 cycles.
- Outputs are registered state or counters. `vga_colour` is combinational from registered values.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then `go` pulse with `startgame`=0:
  - `plot` high for 19200 cycles, all `vga_colour`=3'b001.
  - `done` 19202 cycles after `go`; `hit`=0.
- Game frame with dude (10,20), wall_x=100, gap_y=40:
  - (10,20) and (13,23) are 3'b110.
  - (100,0) and (103,39) are 3'b010.
  - (100,40) and (100,71) are 3'b000.
  - (100,72) is 3'b010.
  - `hit`=0.
- Dude (98,10), wall_x=100, gap_y=40:
  - (100,10) is 3'b110 (player priority).
  - `hit`=1 at `done`.
- Clipping, dude (158,118), wall_x=157:
  - Only the columns and rows on screen are coloured.
  - The sweep ends at (159,119); no wrap to column 0.
- Change `dude_x` and pulse `go` mid-frame:
  - Colours match the latched values.
  - The second `go` is ignored; exactly one `done`.
- Assert `resetn`=0 at pixel 5000:
  - Next cycle `plot`=0, `busy`=0, `hit`=0, no `done`.
  - A subsequent `go` renders a full 19200-pixel frame.
